// File: rtl/odd_parity_checker_serial.sv
`default_nettype none
// ============================================================================
// odd_parity_checker_serial -- strobed serial receiver: start, 3 data bits
// (LSB first), odd parity, stop. Optional macro ERR_COUNT_EN adds err_count.
// Revision: 1.0
// ============================================================================
module odd_parity_checker_serial (
  input  logic       clk,
  input  logic       rst,
  input  logic       bit_en,
  input  logic       in_bit,
  output logic [2:0] data_out,
  output logic       data_valid,
  output logic       parity_err,
  output logic       frame_err,
`ifdef ERR_COUNT_EN
  output logic [7:0] err_count,
`endif
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [2:0] shift_q, shift_d;
  logic       par_q, par_d;
  logic [2:0] data_out_q, data_out_d;
  logic       data_valid_q, data_valid_d;
  logic       parity_err_q, parity_err_d;
  logic       frame_err_q, frame_err_d;
  logic       busy_q, busy_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    par_d        = par_q;
    data_out_d   = data_out_q;
    // Status pulses drop after one cycle whether or not a strobe follows.
    data_valid_d = 1'b0;
    parity_err_d = 1'b0;
    frame_err_d  = 1'b0;
    if (bit_en) begin
      case (state_q)
        S_IDLE: begin
          if (!in_bit) begin
            state_d = S_DATA;
            cnt_d   = 2'd0;
          end
        end
        S_DATA: begin
          shift_d[cnt_q] = in_bit;
          if (cnt_q == 2'd2) begin
            state_d = S_PARITY;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
        S_PARITY: begin
          par_d   = in_bit;
          state_d = S_STOP;
        end
        S_STOP: begin
          if (in_bit) begin
            data_out_d   = shift_q;
            data_valid_d = 1'b1;
            parity_err_d = ~(^{shift_q, par_q});
          end else begin
            frame_err_d  = 1'b1;
          end
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 2'd0;
      shift_q      <= 3'd0;
      par_q        <= 1'b0;
      data_out_q   <= 3'd0;
      data_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;

`ifdef ERR_COUNT_EN
  logic [7:0] err_count_q, err_count_d;

  // Counts on the same edge that launches the error pulse; saturates at 255.
  always_comb begin
    err_count_d = err_count_q;
    if ((parity_err_d || frame_err_d) && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_count_q <= 8'd0;
    end else begin
      err_count_q <= err_count_d;
    end
  end

  assign err_count = err_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_odd_parity_checker_serial.sv
`default_nettype none
// Directed-vector bench for odd_parity_checker_serial.
module tb_odd_parity_checker_serial;

  logic       clk;
  logic       rst;
  logic       bit_en;
  logic       in_bit;
  logic [2:0] data_out;
  logic       data_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;
`ifdef ERR_COUNT_EN
  logic [7:0] err_count;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  odd_parity_checker_serial dut (
    .clk        (clk),
    .rst        (rst),
    .bit_en     (bit_en),
    .in_bit     (in_bit),
    .data_out   (data_out),
    .data_valid (data_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
`ifdef ERR_COUNT_EN
    .err_count  (err_count),
`endif
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One strobed bit followed by `gap` cycles with bit_en low.
  task automatic strobe(input logic b, input int gap);
    @(negedge clk);
    bit_en = 1'b1;
    in_bit = b;
    repeat (gap) begin
      @(negedge clk);
      bit_en = 1'b0;
      in_bit = 1'b1;
    end
  endtask

  // Sends a frame and returns #1 after the edge that samples the stop bit.
  task automatic send_frame(input logic [2:0] d, input logic p, input logic stop, input int gap);
    strobe(1'b0, gap);
    for (int i = 0; i < 3; i++) strobe(d[i], gap);
    strobe(p, gap);
    @(negedge clk);
    bit_en = 1'b1;
    in_bit = stop;
    @(posedge clk);
    #1;
  endtask

  // One quiet cycle; pulses must be gone afterwards.
  task automatic quiet_cycle();
    @(negedge clk);
    bit_en = 1'b0;
    in_bit = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst    = 1'b1;
    bit_en = 1'b0;
    in_bit = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data_out", {5'd0, data_out}, 8'd0);
    check("rst_valid", {7'd0, data_valid}, 8'd0);
    check("rst_perr", {7'd0, parity_err}, 8'd0);
    check("rst_ferr", {7'd0, frame_err}, 8'd0);
    check("rst_busy", {7'd0, busy}, 8'd0);
`ifdef ERR_COUNT_EN
    check("rst_errcnt", err_count, 8'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // d=101, parity 1: good frame
    send_frame(3'b101, 1'b1, 1'b1, 0);
    check("f1_data_out", {5'd0, data_out}, 8'h05);
    check("f1_valid", {7'd0, data_valid}, 8'd1);
    check("f1_perr", {7'd0, parity_err}, 8'd0);
    check("f1_ferr", {7'd0, frame_err}, 8'd0);
    quiet_cycle();
    check("f1_valid_drop", {7'd0, data_valid}, 8'd0);
    check("f1_busy_idle", {7'd0, busy}, 8'd0);

    // d=111, stop 0: framing error, data_out keeps 101; stop-0 is not a start
    send_frame(3'b111, 1'b0, 1'b0, 0);
    check("f2_ferr", {7'd0, frame_err}, 8'd1);
    check("f2_valid", {7'd0, data_valid}, 8'd0);
    check("f2_perr", {7'd0, parity_err}, 8'd0);
    check("f2_data_out", {5'd0, data_out}, 8'h05);
    check("f2_busy", {7'd0, busy}, 8'd0);
`ifdef ERR_COUNT_EN
    check("f2_errcnt", err_count, 8'd1);
`endif
    quiet_cycle();
    check("f2_ferr_drop", {7'd0, frame_err}, 8'd0);

    // d=000, parity 0: parity error, data_out still updated
    send_frame(3'b000, 1'b0, 1'b1, 0);
    check("f3_data_out", {5'd0, data_out}, 8'h00);
    check("f3_valid", {7'd0, data_valid}, 8'd1);
    check("f3_perr", {7'd0, parity_err}, 8'd1);
`ifdef ERR_COUNT_EN
    check("f3_errcnt", err_count, 8'd2);
`endif
    quiet_cycle();
    check("f3_perr_drop", {7'd0, parity_err}, 8'd0);

    // d=110, parity 1 with 3 idle cycles between strobes
    send_frame(3'b110, 1'b1, 1'b1, 3);
    check("f4_data_out", {5'd0, data_out}, 8'h06);
    check("f4_valid", {7'd0, data_valid}, 8'd1);
    check("f4_perr", {7'd0, parity_err}, 8'd0);
    quiet_cycle();
    check("f4_valid_drop", {7'd0, data_valid}, 8'd0);

    // Reset after d[1], with a strobe pending to show rst wins
    strobe(1'b0, 0);
    strobe(1'b1, 0);
    strobe(1'b1, 0);
    @(posedge clk);
    #1;
    check("f5_busy_mid", {7'd0, busy}, 8'd1);
    @(negedge clk);
    rst    = 1'b1;
    bit_en = 1'b1;
    in_bit = 1'b0;
    @(posedge clk);
    #1;
    check("f5_busy_rst", {7'd0, busy}, 8'd0);
    check("f5_valid_rst", {7'd0, data_valid}, 8'd0);
    check("f5_dout_rst", {5'd0, data_out}, 8'h00);
    @(negedge clk);
    rst    = 1'b0;
    bit_en = 1'b0;
    in_bit = 1'b1;
    send_frame(3'b011, 1'b1, 1'b1, 0);
    check("f6_data_out", {5'd0, data_out}, 8'h03);
    check("f6_valid", {7'd0, data_valid}, 8'd1);
    check("f6_perr", {7'd0, parity_err}, 8'd0);
    quiet_cycle();

`ifdef ERR_COUNT_EN
    for (int k = 0; k < 260; k++) begin
      send_frame(3'b000, 1'b0, 1'b1, 0);
    end
    quiet_cycle();
    check("sat_errcnt", err_count, 8'hFF);
    send_frame(3'b001, 1'b1, 1'b0, 0);
    quiet_cycle();
    check("sat_errcnt_hold", err_count, 8'hFF);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
